// File: rtl/ucode_pkg.sv
// rtl/ucode_pkg.sv - shared microcode types, control-word field map and state encoding
package ucode_pkg;

    localparam int CTRL_W  = 69;
    localparam int UADDR_W = 9;

    localparam int SEQ_OP_HI   = 68;
    localparam int SEQ_OP_LO   = 66;
    localparam int NEXT_HI     = 65;
    localparam int NEXT_LO     = 57;
    localparam int MEM_REQ_BIT = 56;

    localparam logic [UADDR_W-1:0] CB_BASE_DEFAULT   = 9'h100;
    localparam logic [UADDR_W-1:0] IRQ_UADDR_DEFAULT = 9'h1E0;
    localparam logic [7:0]         CB_PREFIX         = 8'hCB;

    typedef enum logic [2:0] {
        SEQ_NEXT       = 3'd0,
        SEQ_END        = 3'd1,
        SEQ_END_IF_NOT = 3'd2,
        SEQ_JUMP_IF    = 3'd3,
        SEQ_HALT       = 3'd4,
        SEQ_RSV5       = 3'd5,
        SEQ_RSV6       = 3'd6,
        SEQ_RSV7       = 3'd7
    } seq_op_t;

    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_FETCH_CB = 2'd1,
        ST_EXEC     = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    function automatic seq_op_t ctrl_seq_op(input logic [CTRL_W-1:0] word);
        return seq_op_t'(word[SEQ_OP_HI:SEQ_OP_LO]);
    endfunction

endpackage

// File: rtl/ucode_next_addr.sv
// rtl/ucode_next_addr.sv - combinational successor address/state for a completing micro-step
module ucode_next_addr
    import ucode_pkg::*;
#(
    parameter logic [UADDR_W-1:0] IRQ_UADDR = IRQ_UADDR_DEFAULT
) (
    input  seq_op_t              seq_op,
    input  logic [UADDR_W-1:0]   next_field,
    input  logic [UADDR_W-1:0]   cur_uaddr,
    input  logic                 cond_true,
    input  logic                 irq_pending,
    input  logic                 ime,
    output logic [UADDR_W-1:0]   next_uaddr,
    output state_t               next_state,
    output logic                 irq_entry
);

    logic finish;

    always_comb begin
        next_uaddr = cur_uaddr;
        next_state = ST_EXEC;
        irq_entry  = 1'b0;
        finish     = 1'b0;
        case (seq_op)
            SEQ_NEXT:                    next_uaddr = next_field;
            SEQ_END_IF_NOT, SEQ_JUMP_IF: begin
                if (cond_true) next_uaddr = next_field;
                else           finish     = 1'b1;
            end
            SEQ_HALT:                    next_state = ST_HALT;
            default:                     finish     = 1'b1;
        endcase
        // Instruction boundary: the only point where an interrupt may be taken.
        if (finish) begin
            if (irq_pending && ime) begin
                next_uaddr = IRQ_UADDR;
                irq_entry  = 1'b1;
            end else begin
                next_state = ST_FETCH;
            end
        end
    end

endmodule

// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - microcode sequencer top; UCODE_HALT_BUG_EN enables the HALT-bug PC inhibit
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter logic [UADDR_W-1:0] CB_BASE   = CB_BASE_DEFAULT,
    parameter logic [UADDR_W-1:0] IRQ_UADDR = IRQ_UADDR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           instr_byte,
    input  logic                 instr_valid,
    input  logic [CTRL_W-1:0]    ctrl,
    input  logic                 mem_ready,
    input  logic                 cond_true,
    input  logic                 ime,
    input  logic                 irq_pending,
    output logic [UADDR_W-1:0]   uaddr,
    output logic                 fetch_req,
    output logic                 ctrl_commit,
    output logic                 irq_ack,
    output logic                 halted,
    output logic                 pc_inc_inhibit
);

    state_t              state;
    seq_op_t             seq_op;
    logic                step_done;
    logic [UADDR_W-1:0]  na_uaddr;
    state_t              na_state;
    logic                na_irq;
    logic                ctrl_unused;

    assign seq_op      = ctrl_seq_op(ctrl);
    assign step_done   = !ctrl[MEM_REQ_BIT] || mem_ready;
    assign ctrl_unused = ^ctrl[MEM_REQ_BIT-1:0];

    assign fetch_req   = !rst && (state == ST_FETCH || state == ST_FETCH_CB);
    assign ctrl_commit = !rst && (state == ST_EXEC) && step_done;

    ucode_next_addr #(
        .IRQ_UADDR (IRQ_UADDR)
    ) u_next_addr (
        .seq_op      (seq_op),
        .next_field  (ctrl[NEXT_HI:NEXT_LO]),
        .cur_uaddr   (uaddr),
        .cond_true   (cond_true),
        .irq_pending (irq_pending),
        .ime         (ime),
        .next_uaddr  (na_uaddr),
        .next_state  (na_state),
        .irq_entry   (na_irq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_FETCH;
            uaddr   <= '0;
            irq_ack <= 1'b0;
            halted  <= 1'b0;
        end else begin
            irq_ack <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (instr_valid) begin
                        if (instr_byte == CB_PREFIX) begin
                            state <= ST_FETCH_CB;
                        end else begin
                            uaddr <= {1'b0, instr_byte};
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_FETCH_CB: begin
                    if (instr_valid) begin
                        uaddr <= CB_BASE + {1'b0, instr_byte};
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (step_done) begin
                        uaddr   <= na_uaddr;
                        state   <= na_state;
                        irq_ack <= na_irq;
                        halted  <= (na_state == ST_HALT);
                    end
                end
                ST_HALT: begin
                    // Any pending interrupt wakes the core; ime decides entry vs. plain resume.
                    if (irq_pending) begin
                        halted <= 1'b0;
                        if (ime) begin
                            uaddr   <= IRQ_UADDR;
                            irq_ack <= 1'b1;
                            state   <= ST_EXEC;
                        end else begin
                            state   <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

`ifdef UCODE_HALT_BUG_EN
    logic halt_irq_seen;
    logic bug_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_irq_seen <= 1'b0;
            bug_pending   <= 1'b0;
        end else begin
            if (state == ST_EXEC && step_done && seq_op == SEQ_HALT)
                halt_irq_seen <= irq_pending;
            // Resuming from HALT with an already-pending interrupt re-reads the next byte.
            if (state == ST_HALT && irq_pending && !ime)
                bug_pending <= halt_irq_seen;
            else if (state == ST_FETCH && instr_valid)
                bug_pending <= 1'b0;
        end
    end

    assign pc_inc_inhibit = !rst && bug_pending && (state == ST_FETCH) && instr_valid;
`else
    assign pc_inc_inhibit = 1'b0;
`endif

endmodule
